example_sweep_ctrl: RTL and testbench

EXAMPLE_SWEEP_CTRL -- requirements
Module: example_sweep_ctrl

---
 rtl/example_pkg.sv | 24 ++
 rtl/example_settle_timer.sv | 28 ++
 rtl/example_sweep_ctrl.sv | 127 ++++++++++++
 tb/tb_example_sweep_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/example_pkg.sv
// Shared types and sizes for the example sweep controller.
package example_pkg;

   localparam int unsigned VEC_W   = 6;
   localparam int unsigned NUM_VEC = 64;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned ONES_W  = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Result payload accumulated over one sweep.
   typedef struct packed {
      logic [ONES_W-1:0] ones_cnt;
      logic [VEC_W-1:0]  first_idx;
      logic              found;
      logic              pass;
   } result_t;

endpackage

// File: rtl/example_settle_timer.sv
// Settle down-counter: loadable, decrements toward zero, flags zero.
module example_settle_timer
   import example_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_c
);

   logic [CNT_W-1:0] cnt;

   // Load has priority; decrement saturates at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero_c = (cnt == '0);

endmodule

// File: rtl/example_sweep_ctrl.sv
// Exhaustive 6-input sweep controller: drives every vector, waits for the
// datapath to settle, samples y and accumulates the result summary.
module example_sweep_ctrl
   import example_pkg::*;
#(
   parameter int unsigned SETTLE   = 1,
   parameter int unsigned EXP_ONES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              y,
   output logic [VEC_W-1:0]  vec,
   output logic              busy,
   output logic              done,
   output logic [ONES_W-1:0] ones_cnt,
   output logic [VEC_W-1:0]  first_idx,
   output logic              found,
   output logic              pass
);

   state_t            state;
   state_t            state_nx;
   logic [VEC_W-1:0]  vec_nx;
   result_t           res;
   result_t           res_nx;
   logic [ONES_W-1:0] ones_inc;
   logic              busy_nx;
   logic              done_nx;
   logic              tmr_load;
   logic              tmr_dec;
   logic              tmr_zero;

   example_settle_timer u_settle (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (CNT_W'(SETTLE)),
      .dec      (tmr_dec),
      .zero_c   (tmr_zero)
   );

   // Next-state, next-vector and result update.
   always_comb begin
      state_nx = state;
      vec_nx   = vec;
      res_nx   = res;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      ones_inc = res.ones_cnt + ONES_W'(y);

      case (state)
         IDLE: begin
            if (start) begin
               vec_nx   = '0;
               res_nx   = '0;
               tmr_load = 1'b1;
               state_nx = DRIVE;
            end
         end
         DRIVE: begin
            if (abort) begin
               vec_nx   = '0;
               state_nx = IDLE;
            end else if (tmr_zero) begin
               state_nx = SAMPLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         SAMPLE: begin
            if (abort) begin
               vec_nx   = '0;
               state_nx = IDLE;
            end else begin
               res_nx.ones_cnt = ones_inc;
               if (y && !res.found) begin
                  res_nx.first_idx = vec;
                  res_nx.found     = 1'b1;
               end
               if (vec == VEC_W'(NUM_VEC - 1)) begin
                  // pass must already be valid in the cycle done is high
                  res_nx.pass = (ones_inc == ONES_W'(EXP_ONES));
                  state_nx    = DONE;
               end else begin
                  vec_nx   = vec + VEC_W'(1);
                  tmr_load = 1'b1;
                  state_nx = DRIVE;
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      busy_nx = (state_nx == DRIVE) || (state_nx == SAMPLE);
      done_nx = (state_nx == DONE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         vec   <= '0;
         res   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         vec   <= vec_nx;
         res   <= res_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

   assign ones_cnt  = res.ones_cnt;
   assign first_idx = res.first_idx;
   assign found     = res.found;
   assign pass      = res.pass;

endmodule

// File: tb/tb_example_sweep_ctrl.sv
// Self-checking bench for example_sweep_ctrl. Two instances share the
// control inputs and differ only in EXP_ONES (0 and 64); each sees y taken
// from a 64-bit truth table indexed by its own vec.
module tb_example_sweep_ctrl;

   localparam int unsigned SETTLE   = 1;
   localparam int unsigned PER_VEC  = SETTLE + 2;
   localparam int unsigned DONE_CYC = 1 + 64 * PER_VEC;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [63:0] ypat;

   logic [5:0] vec0, vec1, first0, first1;
   logic [6:0] ones0, ones1;
   logic       busy0, busy1, done0, done1, found0, found1, pass0, pass1;
   logic       y0, y1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign y0 = ypat[vec0];
   assign y1 = ypat[vec1];

   example_sweep_ctrl #(.SETTLE(SETTLE), .EXP_ONES(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .y(y0),
      .vec(vec0), .busy(busy0), .done(done0), .ones_cnt(ones0),
      .first_idx(first0), .found(found0), .pass(pass0)
   );

   example_sweep_ctrl #(.SETTLE(SETTLE), .EXP_ONES(64)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .y(y1),
      .vec(vec1), .busy(busy1), .done(done1), .ones_cnt(ones1),
      .first_idx(first1), .found(found1), .pass(pass1)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference summary over the first n vectors of the truth table.
   function automatic void model(input logic [63:0] pat, input int n,
                                 output int ones, output int first, output bit fnd);
      ones = 0; first = 0; fnd = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (pat[i]) begin
            ones++;
            if (!fnd) begin
               first = i;
               fnd   = 1'b1;
            end
         end
      end
   endfunction

   task automatic check_res(input int n, input bit full);
      int ones, first;
      bit fnd;
      model(ypat, n, ones, first, fnd);
      check_eq("ones0",  64'(ones0),  64'(ones));
      check_eq("ones1",  64'(ones1),  64'(ones));
      check_eq("first0", 64'(first0), 64'(first));
      check_eq("first1", 64'(first1), 64'(first));
      check_eq("found0", 64'(found0), 64'(fnd));
      check_eq("found1", 64'(found1), 64'(fnd));
      check_eq("pass0",  64'(pass0),  64'(full && (ones == 0)));
      check_eq("pass1",  64'(pass1),  64'(full && (ones == 64)));
   endtask

   // k-th cycle after the accepted start: vector (k-1)/PER_VEC is driven.
   task automatic check_step(input int k);
      check_eq("vec0",  64'(vec0),  64'((k - 1) / PER_VEC));
      check_eq("vec1",  64'(vec1),  64'((k - 1) / PER_VEC));
      check_eq("busy0", 64'(busy0), 64'd1);
      check_eq("busy1", 64'(busy1), 64'd1);
      check_eq("done0", 64'(done0), 64'd0);
      check_eq("done1", 64'(done1), 64'd0);
   endtask

   // Called in cycle 1 of a sweep; abort_at=0 runs it to completion.
   task automatic sweep_body(input int abort_at);
      for (int k = 1; k < DONE_CYC; k++) begin
         check_step(k);
         if (k == abort_at) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check_eq("abort_busy0", 64'(busy0), 64'd0);
            check_eq("abort_busy1", 64'(busy1), 64'd0);
            check_eq("abort_vec0",  64'(vec0),  64'd0);
            check_eq("abort_vec1",  64'(vec1),  64'd0);
            check_res((k - 1) / PER_VEC, 1'b0);
            for (int j = 0; j < 5; j++) begin
               check_eq("abort_done0", 64'(done0), 64'd0);
               check_eq("abort_done1", 64'(done1), 64'd0);
               tick();
            end
            check_res((k - 1) / PER_VEC, 1'b0);
            return;
         end
         tick();
      end
      check_eq("done0",     64'(done0), 64'd1);
      check_eq("done1",     64'(done1), 64'd1);
      check_eq("busy_end0", 64'(busy0), 64'd0);
      check_eq("vec_end0",  64'(vec0),  64'd63);
      check_res(64, 1'b1);
   endtask

   task automatic run_sweep(input logic [63:0] pat, input int abort_at);
      ypat  = pat;
      start = 1'b1;
      tick();
      start = 1'b0;
      sweep_body(abort_at);
      if (abort_at == 0) begin
         tick();
         check_eq("post_done0", 64'(done0), 64'd0);
         check_eq("post_busy0", 64'(busy0), 64'd0);
         repeat (3) tick();
         check_res(64, 1'b1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [63:0] pat;

      // Reset with start held high.
      rst = 1'b1; start = 1'b1; abort = 1'b0; ypat = '0;
      tick();
      tick();
      check_eq("rst_vec0",   64'(vec0),   64'd0);
      check_eq("rst_busy0",  64'(busy0),  64'd0);
      check_eq("rst_done0",  64'(done0),  64'd0);
      check_eq("rst_ones0",  64'(ones0),  64'd0);
      check_eq("rst_first0", 64'(first0), 64'd0);
      check_eq("rst_found0", 64'(found0), 64'd0);
      check_eq("rst_pass0",  64'(pass0),  64'd0);
      check_eq("rst_pass1",  64'(pass1),  64'd0);
      rst = 1'b0; start = 1'b0;
      tick();
      check_eq("idle_busy0", 64'(busy0), 64'd0);
      check_eq("idle_vec0",  64'(vec0),  64'd0);

      // Directed truth tables: all zero, single hit at 36, all ones.
      run_sweep(64'd0, 0);
      pat = 64'd1 << 36;
      run_sweep(pat, 0);
      run_sweep({64{1'b1}}, 0);

      // Abort in IDLE is a no-op.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("idle_abort_busy0", 64'(busy0), 64'd0);
      check_res(64, 1'b1);

      // Abort while vec=10, then a full sweep.
      run_sweep({$urandom, $urandom}, 31 + int'($urandom_range(0, 2)));
      run_sweep({$urandom, $urandom}, 0);

      // Random truth tables, dense and sparse.
      for (int i = 0; i < 3; i++) begin
         pat = {$urandom, $urandom};
         if (i == 1) pat = pat & {$urandom, $urandom} & {$urandom, $urandom};
         run_sweep(pat, 0);
      end

      // Start held high: one IDLE cycle between done and the next DRIVE.
      ypat  = {$urandom, $urandom};
      start = 1'b1;
      tick();
      sweep_body(0);
      tick();
      check_eq("held_idle_busy0", 64'(busy0), 64'd0);
      check_eq("held_idle_done0", 64'(done0), 64'd0);
      check_res(64, 1'b1);
      tick();
      check_eq("held_rearm_busy0", 64'(busy0), 64'd1);
      check_eq("held_rearm_vec0",  64'(vec0),  64'd0);
      check_res(0, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         check_step(k);
         tick();
      end

      // Reset mid-sweep abandons it with no done.
      rst = 1'b1; start = 1'b0;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_busy0", 64'(busy0), 64'd0);
      check_eq("mid_rst_vec0",  64'(vec0),  64'd0);
      check_eq("mid_rst_ones0", 64'(ones0), 64'd0);
      for (int k = 0; k < 250; k++) begin
         tick();
         check_eq("mid_rst_done0", 64'(done0), 64'd0);
         check_eq("mid_rst_done1", 64'(done1), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
